// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game input path: key FSM state codes
// (also decoded by the hexa7seg debug display) and a one-hot helper.
package jogo_pkg;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    REGISTRA = 2'd1,
    SOLTA    = 2'd2,
    INVALIDA = 2'd3
  } estado_t;

  localparam int LARGURA_CHAVES = 4;

  // True when exactly one bit of the key vector is set.
  function automatic logic eh_one_hot(input logic [LARGURA_CHAVES-1:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a vector debouncer: the whole vector must
// stay unchanged for DEBOUNCE_CICLOS synchronized cycles before it is accepted.
// Any bit change restarts the count for the entire vector.
module debouncer #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] entrada,
  output logic [WIDTH-1:0] estavel
);

  localparam int CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] K_MAX = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] K_UM  = CW'(1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] cand_r;
  logic [WIDTH-1:0] estavel_r;
  logic [CW-1:0]    cont_r;

  // Bring the asynchronous raw inputs into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= entrada;
      sync2_r <= sync1_r;
    end
  end

  // Track the candidate value and count how long it has stayed unchanged;
  // the counter saturates at N-1 so a long hold never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_r    <= {WIDTH{1'b0}};
      cont_r    <= {CW{1'b0}};
      estavel_r <= {WIDTH{1'b0}};
    end else if (sync2_r != cand_r) begin
      cand_r <= sync2_r;
      cont_r <= {CW{1'b0}};
    end else if (cont_r == K_MAX) begin
      estavel_r <= cand_r;
    end else begin
      cont_r <= cont_r + K_UM;
    end
  end

  assign estavel = estavel_r;

endmodule

// File: rtl/condicionador_entradas.sv
// Input conditioning for the memory game: debounced start button turned into
// a one-cycle pulse, and debounced switches fed to a key FSM that emits one
// play pulse per valid single-key press and rejects multi-key presses.
module condicionador_entradas
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_raw,
  input  logic [3:0] chaves_raw,
  output logic       iniciar_pulso,
  output logic [3:0] chaves_estaveis,
  output logic       jogada_pulso,
  output logic [3:0] jogada_valor,
  output logic       db_invalida,
  output logic [3:0] db_estado
);

  logic       iniciar_est_s;
  logic [3:0] chaves_est_s;
  logic       iniciar_ant_r;
  logic       iniciar_pulso_r;

  estado_t    estado_r;
  estado_t    estado_s;
  logic       pulso_s;
  logic       pulso_r;
  logic [3:0] valor_s;
  logic [3:0] valor_r;
  logic       invalida_s;
  logic       invalida_r;

  debouncer #(
    .WIDTH          (1),
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_db_iniciar (
    .clock  (clock),
    .reset  (reset),
    .entrada(iniciar_raw),
    .estavel(iniciar_est_s)
  );

  debouncer #(
    .WIDTH          (4),
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_db_chaves (
    .clock  (clock),
    .reset  (reset),
    .entrada(chaves_raw),
    .estavel(chaves_est_s)
  );

  // Rising-edge detector on the debounced start button; falling edges ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iniciar_ant_r   <= 1'b0;
      iniciar_pulso_r <= 1'b0;
    end else begin
      iniciar_ant_r   <= iniciar_est_s;
      iniciar_pulso_r <= iniciar_est_s & ~iniciar_ant_r;
    end
  end

  // Key FSM next-state logic; pulse, value and invalid flag are computed for
  // the state being entered so the registered copies line up with it.
  always_comb begin
    estado_s   = estado_r;
    pulso_s    = 1'b0;
    valor_s    = valor_r;
    invalida_s = 1'b0;
    case (estado_r)
      ESPERA: begin
        if (chaves_est_s == 4'b0000) begin
          estado_s = ESPERA;
        end else if (eh_one_hot(chaves_est_s)) begin
          estado_s = REGISTRA;
          pulso_s  = 1'b1;
          valor_s  = chaves_est_s;
        end else begin
          estado_s   = INVALIDA;
          invalida_s = 1'b1;
        end
      end
      REGISTRA: begin
        estado_s = SOLTA;
      end
      SOLTA: begin
        // A slide to another key without passing through zero is not a press.
        if (chaves_est_s == 4'b0000) begin
          estado_s = ESPERA;
        end else begin
          estado_s = SOLTA;
        end
      end
      INVALIDA: begin
        if (chaves_est_s == 4'b0000) begin
          estado_s = ESPERA;
        end else begin
          estado_s   = INVALIDA;
          invalida_s = 1'b1;
        end
      end
      default: begin
        estado_s = ESPERA;
      end
    endcase
  end

  // Key FSM state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r   <= ESPERA;
      pulso_r    <= 1'b0;
      valor_r    <= 4'b0000;
      invalida_r <= 1'b0;
    end else begin
      estado_r   <= estado_s;
      pulso_r    <= pulso_s;
      valor_r    <= valor_s;
      invalida_r <= invalida_s;
    end
  end

  assign iniciar_pulso   = iniciar_pulso_r;
  assign chaves_estaveis = chaves_est_s;
  assign jogada_pulso    = pulso_r;
  assign jogada_valor    = valor_r;
  assign db_invalida     = invalida_r;
  assign db_estado       = {2'b00, estado_r};

endmodule

// File: tb/tb_condicionador_entradas.sv
// Scoreboard bench for condicionador_entradas with N=4. Stimulus pushes the
// expected pulse (edge index, value) into queues; a monitor on the falling
// edge pops and compares whenever a pulse appears, and flags pulses that
// never came. Edge k after a stimulus change applied at edge count b is b+k.
module tb_condicionador_entradas;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar_raw;
  logic [3:0] chaves_raw;
  logic       iniciar_pulso;
  logic [3:0] chaves_estaveis;
  logic       jogada_pulso;
  logic [3:0] jogada_valor;
  logic       db_invalida;
  logic [3:0] db_estado;

  typedef struct {
    int unsigned ciclo;
    logic [3:0]  valor;
  } ev_t;

  ev_t         q_jog[$];
  int unsigned q_ini[$];
  int unsigned edge_cnt = 0;
  int          total = 0;
  int          bad = 0;
  int unsigned b;

  condicionador_entradas #(.DEBOUNCE_CICLOS(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar_raw    (iniciar_raw),
    .chaves_raw     (chaves_raw),
    .iniciar_pulso  (iniciar_pulso),
    .chaves_estaveis(chaves_estaveis),
    .jogada_pulso   (jogada_pulso),
    .jogada_valor   (jogada_valor),
    .db_invalida    (db_invalida),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  // Count rising edges so expectations can name an absolute edge.
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nome, atual, esperado, edge_cnt);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: compare every observed pulse against the scoreboard head and
  // report expected pulses whose edge has gone by without one.
  always @(negedge clock) begin
    if (jogada_pulso === 1'b1) begin
      total++;
      if (q_jog.size() == 0) begin
        bad++;
        $display("FAIL jogada_unexpected: got pulse value %0h at edge %0d expected none", jogada_valor, edge_cnt);
      end else begin
        ev_t e;
        e = q_jog.pop_front();
        if (e.ciclo != edge_cnt || jogada_valor !== e.valor) begin
          bad++;
          $display("FAIL jogada_pulse: got edge %0d value %0h expected edge %0d value %0h",
                   edge_cnt, jogada_valor, e.ciclo, e.valor);
        end
      end
    end
    while (q_jog.size() > 0 && q_jog[0].ciclo < edge_cnt) begin
      total++;
      bad++;
      $display("FAIL jogada_missing: got no pulse expected one at edge %0d value %0h", q_jog[0].ciclo, q_jog[0].valor);
      void'(q_jog.pop_front());
    end
    if (iniciar_pulso === 1'b1) begin
      total++;
      if (q_ini.size() == 0) begin
        bad++;
        $display("FAIL iniciar_unexpected: got pulse at edge %0d expected none", edge_cnt);
      end else begin
        int unsigned c;
        c = q_ini.pop_front();
        if (c != edge_cnt) begin
          bad++;
          $display("FAIL iniciar_pulse: got edge %0d expected edge %0d", edge_cnt, c);
        end
      end
    end
    while (q_ini.size() > 0 && q_ini[0] < edge_cnt) begin
      total++;
      bad++;
      $display("FAIL iniciar_missing: got no pulse expected one at edge %0d", q_ini[0]);
      void'(q_ini.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    iniciar_raw = 1'b0;
    chaves_raw  = 4'b0000;
    ciclos(3);
    check("reset_pulso", {31'd0, jogada_pulso}, 32'd0);
    check("reset_estado", {28'd0, db_estado}, 32'd0);
    reset = 1'b0;
    ciclos(2);
    check("reset_valor", {28'd0, jogada_valor}, 32'd0);
    check("reset_estaveis", {28'd0, chaves_estaveis}, 32'd0);

    // Single key press 0100.
    chaves_raw = 4'b0100;
    b = edge_cnt;
    q_jog.push_back('{b + 8, 4'b0100});
    ciclos(6);
    check("t1_estaveis_e6", {28'd0, chaves_estaveis}, 32'd0);
    ciclos(1);
    check("t1_estaveis_e7", {28'd0, chaves_estaveis}, 32'h4);
    ciclos(1);
    check("t1_estado_e8", {28'd0, db_estado}, 32'd1);
    check("t1_valor_e8", {28'd0, jogada_valor}, 32'h4);
    ciclos(1);
    check("t1_estado_e9", {28'd0, db_estado}, 32'd2);
    ciclos(10);
    check("t1_hold_estado", {28'd0, db_estado}, 32'd2);
    chaves_raw = 4'b0000;
    ciclos(12);
    check("t1_release_estado", {28'd0, db_estado}, 32'd0);

    // Glitchy 0010 toggling every 2 cycles never becomes stable.
    for (int i = 0; i < 10; i++) begin
      chaves_raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      ciclos(2);
      check("t2_glitch_estaveis", {28'd0, chaves_estaveis}, 32'd0);
    end
    chaves_raw = 4'b0000;
    ciclos(10);

    // Two keys at once are rejected.
    chaves_raw = 4'b0011;
    ciclos(12);
    check("t3_estado", {28'd0, db_estado}, 32'd3);
    check("t3_invalida", {31'd0, db_invalida}, 32'd1);
    check("t3_valor_kept", {28'd0, jogada_valor}, 32'h4);
    chaves_raw = 4'b0000;
    ciclos(12);
    check("t3_release_estado", {28'd0, db_estado}, 32'd0);
    check("t3_release_invalida", {31'd0, db_invalida}, 32'd0);

    // Slide 0001 -> 1000 without release gives one pulse only.
    chaves_raw = 4'b0001;
    b = edge_cnt;
    q_jog.push_back('{b + 8, 4'b0001});
    ciclos(12);
    chaves_raw = 4'b1000;
    ciclos(12);
    check("t4_slide_estaveis", {28'd0, chaves_estaveis}, 32'h8);
    check("t4_slide_estado", {28'd0, db_estado}, 32'd2);
    check("t4_slide_valor", {28'd0, jogada_valor}, 32'h1);
    chaves_raw = 4'b0000;
    ciclos(12);
    chaves_raw = 4'b1000;
    b = edge_cnt;
    q_jog.push_back('{b + 8, 4'b1000});
    ciclos(12);
    check("t4_second_valor", {28'd0, jogada_valor}, 32'h8);
    chaves_raw = 4'b0000;
    ciclos(12);

    // Start button held 10 cycles: one pulse at edge 8, none on release.
    iniciar_raw = 1'b1;
    b = edge_cnt;
    q_ini.push_back(b + 8);
    ciclos(10);
    iniciar_raw = 1'b0;
    ciclos(14);

    // Reset while a key is held in SOLTA, then re-acceptance.
    chaves_raw = 4'b0100;
    b = edge_cnt;
    q_jog.push_back('{b + 8, 4'b0100});
    ciclos(12);
    check("t6_pre_estado", {28'd0, db_estado}, 32'd2);
    reset = 1'b1;
    #1;
    check("t6_rst_estado", {28'd0, db_estado}, 32'd0);
    check("t6_rst_valor", {28'd0, jogada_valor}, 32'd0);
    check("t6_rst_estaveis", {28'd0, chaves_estaveis}, 32'd0);
    check("t6_rst_outs", {29'd0, jogada_pulso, iniciar_pulso, db_invalida}, 32'd0);
    ciclos(3);
    reset = 1'b0;
    b = edge_cnt;
    q_jog.push_back('{b + 8, 4'b0100});
    ciclos(12);
    check("t6_after_valor", {28'd0, jogada_valor}, 32'h4);
    chaves_raw = 4'b0000;
    ciclos(12);

    check("end_q_jog_empty", q_jog.size(), 32'd0);
    check("end_q_ini_empty", q_ini.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
